dbus_master_if: RTL and testbench
=================================

Name: dbus_master_if

Overview:
- MEM-stage data-bus master. Converts the single-cycle load/store request from the MEM stage into a Wishbone-style bus transaction with wait states.
- Produces the MEM-stage stall request consumed by the pipeline controller. That request freezes MEM with stall[4]=Stop and stall[5]=NotStop, so a NOP enters WB.
- Holds read data until the stalled pipeline advances.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in BUSY without ack before abort; width of counter = 8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- stall  in  `StallBus (6)  pipeline stall vector from controller; bit 4 = MEM stage
- cpu_ce_i  in  1  MEM stage requests a data access
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address
- cpu_sel_i  in  4  byte lanes
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data to MEM stage
- stallreq_o  out  1  MEM-stage stall request
- bus_err_o  out  1  one-cycle pulse on timeout abort
- bus_adr_o  out  32  bus address
- bus_dat_o  out  32  bus write data
- bus_we_o  out  1  bus write enable
- bus_sel_o  out  4  bus byte select
- bus_stb_o  out  1  strobe
- bus_cyc_o  out  1  cycle valid
- bus_dat_i  in  32  bus read data
- bus_ack_i  in  1  bus acknowledge

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State returns to IDLE.
  - All bus_* outputs, rd_buf and the timeout counter go to 0.
  - bus_err_o goes to 0.
  - An in-flight transaction is dropped; cyc/stb are low after that edge.
- Bus outputs are registered. stallreq_o and cpu_data_o are combinational from state and inputs.
- IDLE:
  - If cpu_ce_i=1, register adr/dat/we/sel from cpu_*, set stb=cyc=1, clear the counter, and go to BUSY.
  - stallreq_o = cpu_ce_i; cpu_data_o = 0.
- BUSY:
  - bus_ack_i=1:
    - Drop stb/cyc/we/sel/adr/dat to 0.
    - Latch bus_dat_i into rd_buf (loads only; stores latch 0).
    - If stall[4]=Stop go to WAIT_STALL, else go to IDLE.
    - Same cycle: stallreq_o=0 and cpu_data_o=bus_dat_i (load) or 0 (store).
  - bus_ack_i=0 and counter=TIMEOUT_CYCLES-1:
    - Drop stb/cyc, set rd_buf=0, pulse bus_err_o for one cycle.
    - Next state as for ack; stallreq_o=0 and cpu_data_o=0 that cycle.
  - Otherwise: counter +1, stallreq_o=1, cpu_data_o=0.
- WAIT_STALL:
  - stallreq_o=0; cpu_data_o=rd_buf.
  - Go to IDLE when stall[4]=NotStop. No new transaction starts from this state.
- Minimum latency: a request seen in IDLE at cycle n has stb at n+1. The earliest ack at n+1 releases stallreq at n+1, so the MEM stage stalls exactly 1 cycle.
- Back-to-back: after a return to IDLE, a new cpu_ce_i starts immediately. There is no dead cycle beyond the IDLE request cycle.
- cpu_* inputs are ignored outside IDLE. The transaction uses the values registered on entry to BUSY.
- bus_ack_i is ignored outside BUSY.
- Ack and timeout in the same cycle: ack wins, no bus_err_o.
- The counter saturates and is never observed outside BUSY.

Decomposition:
- Shared defines header: `StallBus, `Stop/`NotStop, `RstEnable, `ZeroWord, `WriteEnable/Disable, plus new state encodings `DBUS_IDLE=2'b00, `DBUS_BUSY=2'b01, `DBUS_WAIT_STALL=2'b10.
- Single module; no sub-module warranted. The timeout counter stays inline.

Test Plan:
- Load, ack after 3 wait cycles, stall=0: addr 0x0000_0010, ce=1 at cycle 0 → stb/cyc=1 at cycles 1-4, ack at 4 with dat 0xDEADBEEF. stallreq=1 at cycles 0-3 and 0 at 4. cpu_data_o=0xDEADBEEF at 4. IDLE at 5.
- Store, zero-wait ack: we=1, sel=4'b0011, data 0x1234_5678 → bus_we/sel/dat match at cycle 1, ack at 1. stallreq high only at cycle 0. Return to IDLE.
- Load with later-stage stall: ack at cycle 2 with 0xA5A5_A5A5 while stall=6'b011111 for 3 more cycles → WAIT_STALL holds cpu_data_o=0xA5A5_A5A5 and stallreq=0. IDLE on the first cycle stall[4]=0.
- Timeout with TIMEOUT_CYCLES=4, no ack → stb drops after 4 BUSY cycles. bus_err_o=1 for exactly 1 cycle; cpu_data_o=0; stallreq released.
- Reset mid-BUSY: rst=1 at cycle 2 of a pending load → at the next edge cyc=stb=0, stallreq=0, state IDLE. A late ack is ignored.
- Back-to-back loads at 0x4 then 0x8 with 1-cycle acks → second stb rises the cycle after returning to IDLE with adr 0x8. Each returns correct data.

Source files
------------

// File: rtl/dbus_master_if_pkg.sv
// Shared constants and state encoding for the MEM-stage data-bus master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dbus_master_if_pkg;

   localparam int   STALL_W   = 6;      // pipeline stall vector width
   localparam int   MEM_STAGE = 4;      // stall bit owned by the MEM stage
   localparam int   CNT_W     = 8;      // timeout counter width

   localparam logic STOP       = 1'b1;
   localparam logic NOT_STOP   = 1'b0;
   localparam logic RST_ENABLE = 1'b1;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   typedef enum logic [1:0] {
      DBUS_IDLE       = 2'b00,
      DBUS_BUSY       = 2'b01,
      DBUS_WAIT_STALL = 2'b10
   } dbus_state_t;

endpackage

// File: rtl/dbus_master_if.sv
// MEM-stage data-bus master: turns a single-cycle load/store into a Wishbone-style cycle.
// Latency: stb one cycle after the request; data returned combinationally in the ack cycle.
// Backpressure: stallreq_o holds MEM while the bus is busy; rd_buf keeps load data while later stages stall.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall             pipeline stall vector (bit 4 = MEM stage)
//   cpu_*_i / _o      MEM-stage request and load data return
//   stallreq_o        MEM-stage stall request to the pipeline controller
//   bus_err_o         one-cycle pulse after a timeout abort
//   bus_*             registered Wishbone-style master signals, bus_dat_i/bus_ack_i from slave
module dbus_master_if
   import dbus_master_if_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               cpu_ce_i,
   input  logic               cpu_we_i,
   input  logic [31:0]        cpu_addr_i,
   input  logic [3:0]         cpu_sel_i,
   input  logic [31:0]        cpu_data_i,
   output logic [31:0]        cpu_data_o,
   output logic               stallreq_o,
   output logic               bus_err_o,
   output logic [31:0]        bus_adr_o,
   output logic [31:0]        bus_dat_o,
   output logic               bus_we_o,
   output logic [3:0]         bus_sel_o,
   output logic               bus_stb_o,
   output logic               bus_cyc_o,
   input  logic [31:0]        bus_dat_i,
   input  logic               bus_ack_i
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   dbus_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rd_buf;

   logic start;     // request accepted in IDLE
   logic ack_hit;   // slave acked while BUSY
   logic abort;     // timeout expired without ack

   // Only the MEM-stage bit of the stall vector matters here.
   logic unused_stall;
   assign unused_stall = ^{stall[STALL_W-1:MEM_STAGE+1], stall[MEM_STAGE-1:0]};

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state <= DBUS_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      stallreq_o = 1'b0;
      cpu_data_o = ZERO_WORD;
      start      = 1'b0;
      ack_hit    = 1'b0;
      abort      = 1'b0;

      case (state)
         DBUS_IDLE: begin
            stallreq_o = cpu_ce_i;
            if (cpu_ce_i) begin
               start     = 1'b1;
               state_nxt = DBUS_BUSY;
            end
         end

         DBUS_BUSY: begin
            // Ack takes priority over a timeout landing in the same cycle.
            if (bus_ack_i) begin
               ack_hit = 1'b1;
               if (bus_we_o == WRITE_DISABLE) begin
                  cpu_data_o = bus_dat_i;
               end
               state_nxt = (stall[MEM_STAGE] == STOP) ? DBUS_WAIT_STALL : DBUS_IDLE;
            end else if (cnt == CNT_LAST) begin
               abort     = 1'b1;
               state_nxt = (stall[MEM_STAGE] == STOP) ? DBUS_WAIT_STALL : DBUS_IDLE;
            end else begin
               stallreq_o = 1'b1;
            end
         end

         DBUS_WAIT_STALL: begin
            // MEM is frozen by a later stage; keep presenting the returned data.
            cpu_data_o = rd_buf;
            if (stall[MEM_STAGE] == NOT_STOP) begin
               state_nxt = DBUS_IDLE;
            end
         end

         default: begin
            state_nxt = DBUS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         bus_adr_o <= ZERO_WORD;
         bus_dat_o <= ZERO_WORD;
         bus_we_o  <= WRITE_DISABLE;
         bus_sel_o <= 4'b0000;
         bus_stb_o <= 1'b0;
         bus_cyc_o <= 1'b0;
         bus_err_o <= 1'b0;
         rd_buf    <= ZERO_WORD;
         cnt       <= '0;
      end else begin
         bus_err_o <= abort;
         if (start) begin
            bus_adr_o <= cpu_addr_i;
            bus_dat_o <= cpu_data_i;
            bus_we_o  <= cpu_we_i;
            bus_sel_o <= cpu_sel_i;
            bus_stb_o <= 1'b1;
            bus_cyc_o <= 1'b1;
            cnt       <= '0;
         end else if (ack_hit || abort) begin
            bus_adr_o <= ZERO_WORD;
            bus_dat_o <= ZERO_WORD;
            bus_we_o  <= WRITE_DISABLE;
            bus_sel_o <= 4'b0000;
            bus_stb_o <= 1'b0;
            bus_cyc_o <= 1'b0;
            // Stores and aborted loads leave nothing to return.
            rd_buf    <= (ack_hit && (bus_we_o == WRITE_DISABLE)) ? bus_dat_i : ZERO_WORD;
         end else if ((state == DBUS_BUSY) && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dbus_master_if.sv
// Directed bench for dbus_master_if with a short timeout (4 cycles).
// Latency: n/a.
// Backpressure: n/a.
module tb_dbus_master_if;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        cpu_ce_i, cpu_we_i;
   logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
   logic [3:0]  cpu_sel_i;
   logic        stallreq_o, bus_err_o;
   logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
   logic        bus_we_o, bus_stb_o, bus_cyc_o, bus_ack_i;
   logic [3:0]  bus_sel_o;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   dbus_master_if #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .cpu_ce_i   (cpu_ce_i),
      .cpu_we_i   (cpu_we_i),
      .cpu_addr_i (cpu_addr_i),
      .cpu_sel_i  (cpu_sel_i),
      .cpu_data_i (cpu_data_i),
      .cpu_data_o (cpu_data_o),
      .stallreq_o (stallreq_o),
      .bus_err_o  (bus_err_o),
      .bus_adr_o  (bus_adr_o),
      .bus_dat_o  (bus_dat_o),
      .bus_we_o   (bus_we_o),
      .bus_sel_o  (bus_sel_o),
      .bus_stb_o  (bus_stb_o),
      .bus_cyc_o  (bus_cyc_o),
      .bus_dat_i  (bus_dat_i),
      .bus_ack_i  (bus_ack_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge; then drive inputs.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after input changes.
   task automatic settle();
      #1;
   endtask

   task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] data);
      cpu_ce_i   = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_sel_i  = sel;
      cpu_data_i = data;
   endtask

   initial begin
      rst = 1'b1; stall = 6'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
      cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
      bus_dat_i = '0; bus_ack_i = 1'b0;
      step(); step();
      rst = 1'b0;
      settle();

      // ---- reset state
      chk("rst_stb",      {31'b0, bus_stb_o},  32'h0);
      chk("rst_cyc",      {31'b0, bus_cyc_o},  32'h0);
      chk("rst_err",      {31'b0, bus_err_o},  32'h0);
      chk("rst_adr",      bus_adr_o,           32'h0);
      chk("rst_stallreq", {31'b0, stallreq_o}, 32'h0);
      chk("rst_cpu_data", cpu_data_o,          32'h0);

      // ---- load, ack after 3 wait cycles (ack lands on the timeout boundary)
      req(1'b0, 32'h0000_0010, 4'hF, 32'h0);          // cycle 0
      settle();
      chk("ld1_c0_stallreq", {31'b0, stallreq_o}, 32'h1);
      chk("ld1_c0_data",     cpu_data_o,          32'h0);
      step(); cpu_ce_i = 1'b0; settle();              // cycle 1
      chk("ld1_c1_stb",      {31'b0, bus_stb_o},  32'h1);
      chk("ld1_c1_cyc",      {31'b0, bus_cyc_o},  32'h1);
      chk("ld1_c1_adr",      bus_adr_o,           32'h0000_0010);
      chk("ld1_c1_we",       {31'b0, bus_we_o},   32'h0);
      chk("ld1_c1_stallreq", {31'b0, stallreq_o}, 32'h1);
      step(); settle();                               // cycle 2
      chk("ld1_c2_stallreq", {31'b0, stallreq_o}, 32'h1);
      step(); settle();                               // cycle 3
      chk("ld1_c3_stb",      {31'b0, bus_stb_o},  32'h1);
      chk("ld1_c3_stallreq", {31'b0, stallreq_o}, 32'h1);
      step(); bus_ack_i = 1'b1; bus_dat_i = 32'hDEAD_BEEF; settle();  // cycle 4
      chk("ld1_c4_stb",      {31'b0, bus_stb_o},  32'h1);
      chk("ld1_c4_stallreq", {31'b0, stallreq_o}, 32'h0);
      chk("ld1_c4_data",     cpu_data_o,          32'hDEAD_BEEF);
      step(); bus_ack_i = 1'b0; bus_dat_i = '0; settle();             // cycle 5
      chk("ld1_c5_stb",      {31'b0, bus_stb_o},  32'h0);
      chk("ld1_c5_cyc",      {31'b0, bus_cyc_o},  32'h0);
      chk("ld1_c5_err",      {31'b0, bus_err_o},  32'h0);
      chk("ld1_c5_data",     cpu_data_o,          32'h0);
      chk("ld1_c5_stallreq", {31'b0, stallreq_o}, 32'h0);

      // ---- store, zero-wait ack
      req(1'b1, 32'h0000_0020, 4'b0011, 32'h1234_5678);               // cycle 0
      settle();
      chk("st_c0_stallreq", {31'b0, stallreq_o}, 32'h1);
      step(); cpu_ce_i = 1'b0; bus_ack_i = 1'b1; bus_dat_i = 32'hFFFF_FFFF; settle(); // cycle 1
      chk("st_c1_we",       {31'b0, bus_we_o},   32'h1);
      chk("st_c1_sel",      {28'b0, bus_sel_o},  32'h3);
      chk("st_c1_dat",      bus_dat_o,           32'h1234_5678);
      chk("st_c1_adr",      bus_adr_o,           32'h0000_0020);
      chk("st_c1_stallreq", {31'b0, stallreq_o}, 32'h0);
      chk("st_c1_data",     cpu_data_o,          32'h0);
      step(); bus_ack_i = 1'b0; bus_dat_i = '0; cpu_we_i = 1'b0; settle();  // cycle 2
      chk("st_c2_stb",      {31'b0, bus_stb_o},  32'h0);
      chk("st_c2_we",       {31'b0, bus_we_o},   32'h0);
      chk("st_c2_stallreq", {31'b0, stallreq_o}, 32'h0);

      // ---- load held while a later stage stalls
      req(1'b0, 32'h0000_0030, 4'hF, 32'h0);                          // cycle 0
      step(); cpu_ce_i = 1'b0; settle();                              // cycle 1
      chk("ws_c1_stb", {31'b0, bus_stb_o}, 32'h1);
      step(); bus_ack_i = 1'b1; bus_dat_i = 32'hA5A5_A5A5; stall = 6'b011111; settle(); // cycle 2
      chk("ws_c2_data",     cpu_data_o,          32'hA5A5_A5A5);
      chk("ws_c2_stallreq", {31'b0, stallreq_o}, 32'h0);
      // A request presented in WAIT_STALL must not start a cycle.
      step(); bus_ack_i = 1'b0; bus_dat_i = '0;
      req(1'b0, 32'h0000_0034, 4'hF, 32'h0); settle();                // cycle 3
      chk("ws_c3_data",     cpu_data_o,          32'hA5A5_A5A5);
      chk("ws_c3_stallreq", {31'b0, stallreq_o}, 32'h0);
      chk("ws_c3_stb",      {31'b0, bus_stb_o},  32'h0);
      step(); settle();                                               // cycle 4
      chk("ws_c4_data", cpu_data_o,         32'hA5A5_A5A5);
      chk("ws_c4_stb",  {31'b0, bus_stb_o}, 32'h0);
      step(); stall = 6'b0; settle();                                 // cycle 5
      chk("ws_c5_data",     cpu_data_o,          32'hA5A5_A5A5);
      chk("ws_c5_stallreq", {31'b0, stallreq_o}, 32'h0);
      step(); cpu_ce_i = 1'b0; settle();                              // cycle 6: IDLE
      chk("ws_c6_stb",      {31'b0, bus_stb_o},  32'h0);
      chk("ws_c6_data",     cpu_data_o,          32'h0);
      chk("ws_c6_stallreq", {31'b0, stallreq_o}, 32'h0);

      // ---- timeout, no ack
      req(1'b0, 32'h0000_0040, 4'hF, 32'h0);                          // cycle 0
      step(); cpu_ce_i = 1'b0; bus_dat_i = 32'hFFFF_FFFF; settle();   // cycle 1
      chk("to_c1_stb", {31'b0, bus_stb_o}, 32'h1);
      step(); settle();                                               // cycle 2
      chk("to_c2_stallreq", {31'b0, stallreq_o}, 32'h1);
      step(); settle();                                               // cycle 3
      chk("to_c3_stallreq", {31'b0, stallreq_o}, 32'h1);
      step(); settle();                                               // cycle 4: abort
      chk("to_c4_stb",      {31'b0, bus_stb_o},  32'h1);
      chk("to_c4_stallreq", {31'b0, stallreq_o}, 32'h0);
      chk("to_c4_data",     cpu_data_o,          32'h0);
      chk("to_c4_err",      {31'b0, bus_err_o},  32'h0);
      step(); settle();                                               // cycle 5
      chk("to_c5_stb",      {31'b0, bus_stb_o},  32'h0);
      chk("to_c5_cyc",      {31'b0, bus_cyc_o},  32'h0);
      chk("to_c5_err",      {31'b0, bus_err_o},  32'h1);
      chk("to_c5_stallreq", {31'b0, stallreq_o}, 32'h0);
      step(); bus_dat_i = '0; settle();                               // cycle 6
      chk("to_c6_err", {31'b0, bus_err_o}, 32'h0);

      // ---- reset in the middle of a pending load
      req(1'b0, 32'h0000_0050, 4'hF, 32'h0);                          // cycle 0
      step(); cpu_ce_i = 1'b0; settle();                              // cycle 1
      chk("rb_c1_stb", {31'b0, bus_stb_o}, 32'h1);
      step(); rst = 1'b1; settle();                                   // cycle 2
      step(); rst = 1'b0; bus_ack_i = 1'b1; bus_dat_i = 32'h5555_AAAA; settle(); // cycle 3
      chk("rb_c3_stb",      {31'b0, bus_stb_o},  32'h0);
      chk("rb_c3_cyc",      {31'b0, bus_cyc_o},  32'h0);
      chk("rb_c3_adr",      bus_adr_o,           32'h0);
      chk("rb_c3_stallreq", {31'b0, stallreq_o}, 32'h0);
      chk("rb_c3_data",     cpu_data_o,          32'h0);
      step(); bus_ack_i = 1'b0; bus_dat_i = '0; settle();             // cycle 4
      chk("rb_c4_stb",  {31'b0, bus_stb_o}, 32'h0);
      chk("rb_c4_err",  {31'b0, bus_err_o}, 32'h0);
      chk("rb_c4_data", cpu_data_o,         32'h0);

      // ---- back-to-back loads
      req(1'b0, 32'h0000_0004, 4'hF, 32'h0);                          // cycle 0
      step(); req(1'b0, 32'h0000_0008, 4'hF, 32'h0);
      bus_ack_i = 1'b1; bus_dat_i = 32'h1111_1111; settle();          // cycle 1
      chk("bb_c1_adr",      bus_adr_o,           32'h0000_0004);
      chk("bb_c1_data",     cpu_data_o,          32'h1111_1111);
      chk("bb_c1_stallreq", {31'b0, stallreq_o}, 32'h0);
      step(); bus_ack_i = 1'b0; bus_dat_i = '0; settle();             // cycle 2: IDLE
      chk("bb_c2_stb",      {31'b0, bus_stb_o},  32'h0);
      chk("bb_c2_stallreq", {31'b0, stallreq_o}, 32'h1);
      step(); cpu_ce_i = 1'b0; bus_ack_i = 1'b1; bus_dat_i = 32'h2222_2222; settle(); // cycle 3
      chk("bb_c3_stb",  {31'b0, bus_stb_o}, 32'h1);
      chk("bb_c3_adr",  bus_adr_o,          32'h0000_0008);
      chk("bb_c3_data", cpu_data_o,         32'h2222_2222);
      step(); bus_ack_i = 1'b0; bus_dat_i = '0; settle();             // cycle 4
      chk("bb_c4_stb",  {31'b0, bus_stb_o}, 32'h0);
      chk("bb_c4_data", cpu_data_o,         32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
